// File: rtl/pbit_readout_pkg.sv
// rtl/pbit_readout_pkg.sv - shared state encoding, window limits and log clamp for the p-bit readout averager
package pbit_readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURN  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_MAX_LOG = 8;
    localparam int DEF_CNT_W   = DEF_MAX_LOG + 1;

    // Saturates the requested log2 window to the largest supported one.
    function automatic logic [3:0] clamp_log(input logic [3:0] log_req, input logic [3:0] log_max);
        return (log_req > log_max) ? log_max : log_req;
    endfunction

endpackage

// File: rtl/pbit_bit_counter.sv
// rtl/pbit_bit_counter.sv - per-bit ones counter with majority compare against half the window
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : synchronous clear (restart of a measurement)
//   en           : add bit_in to the count this edge
//   bit_in       : sampled stochastic bit
//   log_l        : latched log2 window
//   decision     : majority of the count including the current bit_in sample
module pbit_bit_counter #(
    parameter int CNT_W = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    input  logic [3:0] log_l,
    output logic       decision
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] half;
    logic [CNT_W:0]   count_incl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(bit_in);
        end
    end

    // Half window is zero for a single-sample window, so the decision
    // then collapses to the sample itself.
    always_comb begin
        half = '0;
        if (log_l != 4'd0) begin
            half = CNT_W'(1) << (log_l - 4'd1);
        end
    end

    // The final sample is still in flight on the deciding edge, so it is
    // folded in here rather than waiting for the register to catch up.
    assign count_incl = {1'b0, count} + (CNT_W + 1)'(bit_in);
    assign decision   = count_incl > {1'b0, half};

endmodule

// File: rtl/pbit_readout_averager.sv
// rtl/pbit_readout_averager.sv - windowed per-bit majority readout of the annealed adder outputs
//   clk, reset          : clock, asynchronous active-high reset
//   start               : begin or restart a measurement (honoured in every state)
//   log_steps, burn_in  : log2 window and discarded settle cycles, latched on start
//   a_in, b_in, sum_in, ovf_in : adder stochastic outputs, sampled each ACCUM edge
//   busy                : high in BURN or ACCUM
//   done                : one-cycle pulse when results update
//   result_valid        : high while results are held in DONE
//   a_avg, b_avg, sum_avg, ovf_avg : per-bit majority decisions
module pbit_readout_averager
    import pbit_readout_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_LOG = DEF_MAX_LOG,
    parameter int BURN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        log_steps,
    input  logic [BURN_W-1:0] burn_in,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic [WIDTH-1:0]  sum_in,
    input  logic              ovf_in,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic [WIDTH-1:0]  a_avg,
    output logic [WIDTH-1:0]  b_avg,
    output logic [WIDTH-1:0]  sum_avg,
    output logic              ovf_avg
);

    localparam int CNT_W = MAX_LOG + 1;
    localparam int NB    = 3 * WIDTH + 1;

    state_t            state, state_next;
    logic [BURN_W-1:0] burn_cnt;
    logic [CNT_W-1:0]  samp_cnt;
    logic [CNT_W-1:0]  window;
    logic [3:0]        l_reg;
    logic              last_sample;
    logic              acc_en;
    logic              done_q;
    logic [NB-1:0]     bits_in;
    logic [NB-1:0]     decisions;

    assign bits_in     = {ovf_in, sum_in, b_in, a_in};
    assign window      = CNT_W'(1) << l_reg;
    assign last_sample = (samp_cnt == window - CNT_W'(1));
    assign acc_en      = (state == ST_ACCUM) && !start;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bit
            pbit_bit_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .clear    (start),
                .en       (acc_en),
                .bit_in   (bits_in[gi]),
                .log_l    (l_reg),
                .decision (decisions[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = (burn_in != '0) ? ST_BURN : ST_ACCUM;
        end else begin
            case (state)
                ST_BURN:  if (burn_cnt == BURN_W'(1)) state_next = ST_ACCUM;
                ST_ACCUM: if (last_sample) state_next = ST_DONE;
                default:  state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burn_cnt <= '0;
            samp_cnt <= '0;
            l_reg    <= '0;
            done_q   <= 1'b0;
            a_avg    <= '0;
            b_avg    <= '0;
            sum_avg  <= '0;
            ovf_avg  <= 1'b0;
        end else if (start) begin
            burn_cnt <= burn_in;
            samp_cnt <= '0;
            l_reg    <= clamp_log(log_steps, 4'(MAX_LOG));
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_BURN: begin
                    burn_cnt <= burn_cnt - BURN_W'(1);
                end
                ST_ACCUM: begin
                    samp_cnt <= samp_cnt + CNT_W'(1);
                    if (last_sample) begin
                        done_q  <= 1'b1;
                        a_avg   <= decisions[WIDTH-1:0];
                        b_avg   <= decisions[2*WIDTH-1:WIDTH];
                        sum_avg <= decisions[3*WIDTH-1:2*WIDTH];
                        ovf_avg <= decisions[3*WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state == ST_BURN) || (state == ST_ACCUM);
    assign done         = done_q;
    assign result_valid = (state == ST_DONE);

endmodule

// File: tb/tb_pbit_readout_averager.sv
// tb/tb_pbit_readout_averager.sv - directed self-checking bench for pbit_readout_averager
module tb_pbit_readout_averager;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] log_steps = 4'd0;
    logic [7:0] burn_in = 8'd0;
    logic [3:0] a_in = 4'd0, b_in = 4'd0, sum_in = 4'd0;
    logic       ovf_in = 1'b0;
    logic       busy, done, result_valid;
    logic [3:0] a_avg, b_avg, sum_avg;
    logic       ovf_avg;

    int n_cmp = 0;
    int n_bad = 0;
    int k;

    always #5 clk = ~clk;

    pbit_readout_averager #(.WIDTH(4), .MAX_LOG(8), .BURN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .log_steps(log_steps), .burn_in(burn_in),
        .a_in(a_in), .b_in(b_in), .sum_in(sum_in), .ovf_in(ovf_in),
        .busy(busy), .done(done), .result_valid(result_valid),
        .a_avg(a_avg), .b_avg(b_avg), .sum_avg(sum_avg), .ovf_avg(ovf_avg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the current negedge until done is seen; -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic run_pattern(input logic [7:0] pat, input string tag, input logic exp_bit);
        log_steps = 4'd3; burn_in = 8'd0;
        a_in = 4'd0; b_in = 4'd0; sum_in = 4'd0; ovf_in = 1'b0;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            sum_in = {3'b000, pat[7-i]};
            @(negedge clk);
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_sum"}, sum_avg, {3'b000, exp_bit});
    endtask

    task automatic scenario_const();
        a_in = 4'd1; b_in = 4'd7; sum_in = 4'd8; ovf_in = 1'b0;
        log_steps = 4'd3; burn_in = 8'd0;
        pulse_start();
        wait_done(k);
        check("c_latency", k, 8);
        check("c_a", a_avg, 4'd1);
        check("c_b", b_avg, 4'd7);
        check("c_sum", sum_avg, 4'd8);
        check("c_ovf", ovf_avg, 1'b0);
        check("c_valid", result_valid, 1'b1);
        @(negedge clk);
        check("c_done_pulse", done, 1'b0);
        check("c_busy_after", busy, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", result_valid, 1'b0);
        check("rst_avgs", {a_avg, b_avg, sum_avg, ovf_avg}, 13'd0);
        @(negedge clk);
        reset = 1'b0;

        scenario_const();

        run_pattern(8'b1010_1010, "tie", 1'b0);
        run_pattern(8'b1011_0101, "five", 1'b1);

        // Burn-in: 15s during the discarded cycles, then b=3.
        a_in = 4'd15; b_in = 4'd15; sum_in = 4'd15; ovf_in = 1'b1;
        log_steps = 4'd2; burn_in = 8'd4;
        pulse_start();
        check("burn_busy", busy, 1'b1);
        repeat (4) @(negedge clk);
        check("burn_no_early_done", done, 1'b0);
        a_in = 4'd0; b_in = 4'd3; sum_in = 4'd0; ovf_in = 1'b0;
        wait_done(k);
        check("burn_latency", k, 4);
        check("burn_b", b_avg, 4'd3);
        check("burn_a", a_avg, 4'd0);
        check("burn_ovf", ovf_avg, 1'b0);

        // Restart three samples into an eight-sample window.
        a_in = 4'd0; b_in = 4'd2; sum_in = 4'd0;
        log_steps = 4'd3; burn_in = 8'd0;
        pulse_start();
        check("rs_valid_drop", result_valid, 1'b0);
        check("rs_avg_hold", b_avg, 4'd3);
        repeat (2) @(negedge clk);
        b_in = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        check("rs_latency", k, 8);
        check("rs_b", b_avg, 4'd9);

        // Oversized log saturates to a 256-sample window.
        b_in = 4'd0; sum_in = 4'd5;
        log_steps = 4'd12; burn_in = 8'd0;
        pulse_start();
        wait_done(k);
        check("sat_latency", k, 256);
        check("sat_sum", sum_avg, 4'd5);

        // Reset mid-BURN.
        burn_in = 8'd10; log_steps = 4'd2;
        pulse_start();
        repeat (2) @(negedge clk);
        check("rb_busy_pre", busy, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("rb_busy", busy, 1'b0);
        check("rb_sum", sum_avg, 4'd0);
        check("rb_valid", result_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-DONE.
        scenario_const();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rd_valid", result_valid, 1'b0);
        check("rd_avgs", {a_avg, b_avg, sum_avg, ovf_avg}, 13'd0);
        @(negedge clk);
        reset = 1'b0;

        scenario_const();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
